// File: rtl/sorter_pkg.sv
// Shared types and helpers for the sorter consumer side: the sorted 4-tuple
// payload, the byte-lane index, lane selection and the sortedness check.
package sorter_pkg;

  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] mx;
    logic [DATA_W-1:0] smx;
    logic [DATA_W-1:0] smn;
    logic [DATA_W-1:0] mn;
  } sort_tuple_t;

  typedef logic [1:0] lane_t;

  // Byte of a tuple for a given lane; ascending order walks the lanes backwards.
  function automatic logic [DATA_W-1:0] lane_sel(sort_tuple_t t, lane_t lane, bit desc);
    lane_t             idx;
    logic [DATA_W-1:0] res;
    idx = desc ? lane : ~lane;
    case (idx)
      2'd0:    res = t.mx;
      2'd1:    res = t.smx;
      2'd2:    res = t.smn;
      default: res = t.mn;
    endcase
    return res;
  endfunction

  function automatic logic is_sorted(sort_tuple_t t);
    return (t.mx >= t.smx) && (t.smx >= t.smn) && (t.smn >= t.mn);
  endfunction

endpackage

// File: rtl/sort_tuple_fifo.sv
// Power-of-two deep FIFO of sorted tuples with occupancy count.
module sort_tuple_fifo
  import sorter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  sort_tuple_t                  wr_data,
  output sort_tuple_t                  rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  sort_tuple_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/sort_result_serializer.sv
// Buffers sorted 4-tuples and streams them out a byte per cycle, flagging
// dropped tuples and tuples that violate the sorter's ordering.
module sort_result_serializer #(
  parameter int unsigned DATA_W     = sorter_pkg::DATA_W,
  parameter int unsigned DEPTH      = 4,
  parameter bit          ORDER_DESC = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           max,
  input  logic [DATA_W-1:0]           second_max,
  input  logic [DATA_W-1:0]           second_min,
  input  logic [DATA_W-1:0]           min,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow,
  output logic                        order_err
);

  import sorter_pkg::*;

  sort_tuple_t in_tuple;
  sort_tuple_t head;
  lane_t       lane;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        xfer;

  assign in_tuple = '{mx: max, smx: second_max, smn: second_min, mn: min};

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (lane == 2'd3);
  assign out_data  = out_valid ? lane_sel(head, lane, ORDER_DESC) : '0;
  assign out_last  = out_valid && (lane == 2'd3);

  sort_tuple_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_tuple),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Lane walks 0..3 and wraps naturally as the head tuple is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (xfer)                   lane      <= lane + 2'd1;
      if (in_valid && full)       overflow  <= 1'b1;
      if (push && !is_sorted(in_tuple)) order_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed bench for sort_result_serializer: descending and ascending instances
// share stimulus and are checked against a tuple scoreboard every cycle.
module tb_sort_result_serializer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] mx, smx, smn, mn;

  logic          d_in_ready, d_out_valid, d_out_last, d_overflow, d_order_err;
  logic [DW-1:0] d_out_data;
  logic [CW-1:0] d_count;
  logic          a_in_ready, a_out_valid, a_out_last, a_overflow, a_order_err;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_count;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: accepted tuples {mx,smx,smn,mn} plus model state.
  logic [31:0] exp_q[$];
  int          m_count = 0;
  logic [1:0]  m_lane  = 2'd0;
  logic        m_ovf   = 1'b0;
  logic        m_err   = 1'b0;

  always #5 clk = ~clk;

  sort_result_serializer #(.DATA_W(DW), .DEPTH(DEPTH), .ORDER_DESC(1'b1)) u_desc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
    .max(mx), .second_max(smx), .second_min(smn), .min(mn),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_last(d_out_last), .count(d_count), .overflow(d_overflow), .order_err(d_order_err)
  );

  sort_result_serializer #(.DATA_W(DW), .DEPTH(DEPTH), .ORDER_DESC(1'b0)) u_asc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .max(mx), .second_max(smx), .second_min(smn), .min(mn),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_last(a_out_last), .count(a_count), .overflow(a_overflow), .order_err(a_order_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_byte(input logic [31:0] t, input logic [1:0] lane,
                                             input bit desc);
    int idx;
    idx = desc ? int'(lane) : 3 - int'(lane);
    return t[8*(3-idx) +: 8];
  endfunction

  // Per-cycle model check away from the active edge, then advance the model.
  always @(negedge clk) begin
    logic        vld;
    logic        acc;
    logic [31:0] t;
    if (rst) begin
      exp_q.delete();
      m_count = 0;
      m_lane  = 2'd0;
      m_ovf   = 1'b0;
      m_err   = 1'b0;
    end else begin
      vld = (m_count != 0);
      check("d_in_ready",  32'(d_in_ready),  32'(m_count != DEPTH));
      check("a_in_ready",  32'(a_in_ready),  32'(m_count != DEPTH));
      check("d_out_valid", 32'(d_out_valid), 32'(vld));
      check("a_out_valid", 32'(a_out_valid), 32'(vld));
      check("d_count",     32'(d_count),     32'(m_count));
      check("a_count",     32'(a_count),     32'(m_count));
      check("d_overflow",  32'(d_overflow),  32'(m_ovf));
      check("a_order_err", 32'(a_order_err), 32'(m_err));
      check("d_out_last",  32'(d_out_last),  32'(vld && m_lane == 2'd3));
      check("a_out_last",  32'(a_out_last),  32'(vld && m_lane == 2'd3));
      if (vld) begin
        check("d_out_data", 32'(d_out_data), 32'(exp_byte(exp_q[0], m_lane, 1'b1)));
        check("a_out_data", 32'(a_out_data), 32'(exp_byte(exp_q[0], m_lane, 1'b0)));
      end else begin
        check("d_out_data_idle", 32'(d_out_data), 32'(0));
        check("a_out_data_idle", 32'(a_out_data), 32'(0));
      end
      acc = in_valid && (m_count != DEPTH);
      if (in_valid && !acc) m_ovf = 1'b1;
      if (acc) begin
        t = {mx, smx, smn, mn};
        exp_q.push_back(t);
        if (!(mx >= smx && smx >= smn && smn >= mn)) m_err = 1'b1;
        m_count++;
      end
      if (vld && out_ready) begin
        if (m_lane == 2'd3) begin
          void'(exp_q.pop_front());
          m_count--;
        end
        m_lane = m_lane + 2'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] a, b, c, d);
    in_valid = 1'b1;
    mx = a; smx = b; smn = c; mn = d;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mx = '0; smx = '0; smn = '0; mn = '0;
    step(); step();
    check("rst_in_ready",  32'(d_in_ready),  32'(1));
    check("rst_out_valid", 32'(d_out_valid), 32'(0));
    check("rst_out_data",  32'(a_out_data),  32'(0));
    rst = 1'b0;
    step();

    // Single sorted tuple, continuous ready.
    drive(8'hF0, 8'h80, 8'h10, 8'h01);
    step();
    in_valid = 1'b0;
    check("lat_d_first", 32'(d_out_data), 32'(8'hF0));
    check("lat_a_first", 32'(a_out_data), 32'(8'h01));
    wait_drain("drain_single");
    check("single_count", 32'(d_count), 32'(0));

    // Fill with ready low, fifth tuple dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'(8'hE0 + i), 8'(8'hA0 + i), 8'(8'h40 + i), 8'(8'h20 + i));
      step();
    end
    in_valid = 1'b0;
    check("full_count",     32'(d_count),    32'(4));
    check("full_in_ready",  32'(a_in_ready), 32'(0));
    check("full_overflow",  32'(a_overflow), 32'(1));
    out_ready = 1'b1;
    wait_drain("drain_full");
    check("ovf_sticky", 32'(d_overflow), 32'(1));

    // Back-pressure toggling mid-tuple.
    drive(8'h99, 8'h77, 8'h55, 8'h33);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    out_ready = 1'b1;
    wait_drain("drain_toggle");

    // Unsorted tuple still streamed, error sticky.
    drive(8'h10, 8'h20, 8'h05, 8'h01);
    step();
    in_valid = 1'b0;
    check("order_err_set", 32'(d_order_err), 32'(1));
    wait_drain("drain_unsorted");
    check("order_err_sticky", 32'(a_order_err), 32'(1));

    // Async reset after two bytes.
    drive(8'hC0, 8'hB0, 8'hA0, 8'h90);
    step();
    in_valid = 1'b0;
    step(); step();
    check("pre_rst_d_byte", 32'(d_out_data), 32'(8'hA0));
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(d_out_valid), 32'(0));
    check("async_count",     32'(a_count),     32'(0));
    check("async_overflow",  32'(d_overflow),  32'(0));
    check("async_order_err", 32'(a_order_err), 32'(0));
    check("async_out_last",  32'(d_out_last),  32'(0));
    step(); step();
    rst = 1'b0;
    step();
    drive(8'hA5, 8'h5A, 8'h33, 8'h11);
    step();
    in_valid = 1'b0;
    check("post_rst_d_lane0", 32'(d_out_data), 32'(8'hA5));
    check("post_rst_a_lane0", 32'(a_out_data), 32'(8'h11));
    wait_drain("drain_post_rst");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
